// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - fetch-stage signal bundle: imem request/response, decode output, redirect
//
// master : instruction_fetch side (drives request, decode output)
// slave  : environment side (memory, decode, execute redirect)
//   ImemReqValid/ImemReqReady/ImemAddr   fetch request
//   ImemRspValid/ImemRspData             in-order response, never back-pressured
//   InstValid/InstReady/Inst/PCPlus4     head entry toward decode
//   BranchTaken/BranchTarget             redirect from execute
interface instruction_fetch_if;
  logic        ImemReqValid;
  logic        ImemReqReady;
  logic [31:0] ImemAddr;
  logic        ImemRspValid;
  logic [31:0] ImemRspData;
  logic        InstValid;
  logic        InstReady;
  logic [31:0] Inst;
  logic [31:0] PCPlus4;
  logic        BranchTaken;
  logic [31:0] BranchTarget;

  modport master (
    output ImemReqValid, ImemAddr, InstValid, Inst, PCPlus4,
    input  ImemReqReady, ImemRspValid, ImemRspData, InstReady, BranchTaken, BranchTarget
  );

  modport slave (
    input  ImemReqValid, ImemAddr, InstValid, Inst, PCPlus4,
    output ImemReqReady, ImemRspValid, ImemRspData, InstReady, BranchTaken, BranchTarget
  );
endinterface

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC, credit-limited imem fetch, instruction FIFO and branch redirect
//
// Parameters: RESET_PC (PC after reset), DEPTH (FIFO entries and request credit, power of two, >= 2)
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   bus (master)         imem request/response, decode handshake, branch redirect
//   FetchCount           words pushed into the FIFO        (IFETCH_STATS_EN only)
//   DropCount            words discarded by flush or drop  (IFETCH_STATS_EN only)
// Optional feature macro: IFETCH_STATS_EN
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]         FetchCount,
  output logic [31:0]         DropCount
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW-1:0] sq_wr, sq_rd;
  logic [31:0]   last_inst, last_pc4;

  // Storage arrays carry no reset; only pointers and counts do.
  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   pc4_mem  [DEPTH];
  logic [31:0]   shadow   [DEPTH];

  logic [CW:0]   credit_used;
  logic          issue, rsp_ok, push, pop;

  assign credit_used      = {1'b0, outstanding} + {1'b0, count};
  assign bus.ImemReqValid = !reset && !bus.BranchTaken && (credit_used < (CW+1)'(DEPTH));
  assign bus.ImemAddr     = pc;
  assign issue            = bus.ImemReqValid && bus.ImemReqReady;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign rsp_ok = bus.ImemRspValid && (outstanding != '0);
  // Stale words (drop pending) and words arriving with a redirect never enter the FIFO.
  assign push   = rsp_ok && (drop == '0) && !bus.BranchTaken;

  assign bus.InstValid = (count != '0);
  assign pop           = bus.InstValid && bus.InstReady && !bus.BranchTaken;
  // With the FIFO empty, decode keeps seeing the last head that was presented.
  assign bus.Inst      = bus.InstValid ? data_mem[rd_ptr] : last_inst;
  assign bus.PCPlus4   = bus.InstValid ? pc4_mem[rd_ptr]  : last_pc4;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      sq_wr       <= '0;
      sq_rd       <= '0;
      last_inst   <= '0;
      last_pc4    <= '0;
    end else begin
      if (bus.InstValid) begin
        last_inst <= data_mem[rd_ptr];
        last_pc4  <= pc4_mem[rd_ptr];
      end
      outstanding <= outstanding + CW'(issue) - CW'(rsp_ok);
      if (issue) begin
        pc    <= pc + 32'd4;
        sq_wr <= sq_wr + AW'(1);
      end
      if (rsp_ok) sq_rd <= sq_rd + AW'(1);
      if (bus.BranchTaken) begin
        // Issue is blocked this cycle, so every remaining in-flight word is stale.
        pc     <= {bus.BranchTarget[31:2], 2'b00};
        drop   <= outstanding - CW'(rsp_ok);
        count  <= '0;
        rd_ptr <= wr_ptr;
      end else begin
        if (rsp_ok && (drop != '0)) drop <= drop - CW'(1);
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Shadow queue holds issue addresses of in-flight requests, popped in response order.
  always_ff @(posedge clk) begin
    if (issue) shadow[sq_wr] <= pc;
    if (push) begin
      data_mem[wr_ptr] <= bus.ImemRspData;
      pc4_mem[wr_ptr]  <= shadow[sq_rd] + 32'd4;
    end
  end

`ifdef IFETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      FetchCount <= '0;
      DropCount  <= '0;
    end else begin
      FetchCount <= FetchCount + 32'(push);
      DropCount  <= DropCount + 32'(rsp_ok && !push)
                  + (bus.BranchTaken ? 32'(count) : 32'd0);
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;
  localparam logic [31:0] RPC   = 32'h100;
  localparam int          DEPTH = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instruction_fetch_if bus();
`ifdef IFETCH_STATS_EN
  logic [31:0] fetch_count, drop_count;
`endif

  instruction_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef IFETCH_STATS_EN
    , .FetchCount(fetch_count)
    , .DropCount(drop_count)
`endif
  );

  typedef struct { logic [31:0] addr; int ep; int due; } req_t;
  typedef struct {
    logic rst, rdy, irdy, br; logic [31:0] tgt;
    logic e_rv; logic [31:0] e_addr; logic e_iv; logic [31:0] e_p4; logic [31:0] e_inst;
  } vec_t;

  int tests = 0, fails = 0, cyc = 0;
  int lat_min = 1, lat_max = 1;
  logic spurious = 1'b0;
  req_t q[$];
  int epoch = 0, last_due = 0, buffered = 0;
  logic [31:0] exp_issue, exp_del;
  int m_fetch = 0, m_drop = 0;
  logic s_rv, s_iv;
  logic [31:0] s_addr, s_p4, s_inst;
  logic pop_seen = 1'b0; logic [31:0] pop_p4, pop_inst;
  int issue_seen = 0; logic [31:0] first_issue;

  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F96;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: delivered stream is consecutive words from the last reset/redirect;
  // requests issued before a redirect (older epoch) never reach decode.
  task automatic model();
    logic br, fresh, pop;
    req_t e;
    int d;
    br = bus.BranchTaken;
    s_rv = bus.ImemReqValid; s_addr = bus.ImemAddr; s_iv = bus.InstValid;
    s_p4 = bus.PCPlus4;      s_inst = bus.Inst;
    if (reset) begin
      check("req_valid_in_reset", 32'(s_rv), 32'd0);
      q.delete(); buffered = 0; exp_issue = RPC; exp_del = RPC; epoch++;
      last_due = 0; m_fetch = 0; m_drop = 0;
      return;
    end
    check("req_valid", 32'(s_rv), 32'(!br && (q.size() + buffered < DEPTH)));
    if (s_rv) check("imem_addr", s_addr, exp_issue);
    check("inst_valid", 32'(s_iv), 32'(buffered != 0));
    if (s_iv && buffered != 0) begin
      check("pcplus4", s_p4, exp_del + 32'd4);
      check("inst", s_inst, f(exp_del));
    end
    check("credit_cap", 32'(q.size() + buffered <= DEPTH), 32'd1);
    fresh = 1'b0;
    pop = s_iv && bus.InstReady && !br && (buffered != 0);
    if (pop) begin pop_seen = 1'b1; pop_p4 = s_p4; pop_inst = s_inst; end
    if (bus.ImemRspValid && q.size() > 0) begin
      e = q.pop_front();
      fresh = (e.ep == epoch) && !br;
      if (fresh) m_fetch++; else m_drop++;
    end
    if (s_rv && bus.ImemReqReady) begin
      if (issue_seen == 0) first_issue = s_addr;
      issue_seen++;
      d = cyc + $urandom_range(lat_min, lat_max);
      if (d <= last_due) d = last_due + 1;
      e.addr = exp_issue; e.ep = epoch; e.due = d;
      q.push_back(e);
      last_due = d;
      exp_issue += 32'd4;
    end
    if (br) begin
      m_drop += buffered; buffered = 0;
      exp_issue = {bus.BranchTarget[31:2], 2'b00}; exp_del = exp_issue; epoch++;
    end else begin
      if (pop) begin buffered--; exp_del += 32'd4; end
      if (fresh) buffered++;
    end
  endtask

  task automatic tick();
    if (spurious) begin
      bus.ImemRspValid = 1'b1; bus.ImemRspData = $urandom;
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      bus.ImemRspValid = 1'b1; bus.ImemRspData = f(q[0].addr);
    end else begin
      bus.ImemRspValid = 1'b0; bus.ImemRspData = $urandom;
    end
    @(negedge clk);
    model();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic wait_pop(input string name);
    pop_seen = 1'b0;
    for (int i = 0; i < 30 && !pop_seen; i++) tick();
    check(name, 32'(pop_seen), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    logic [31:0] hold_p4, hold_inst;
`ifdef IFETCH_STATS_EN
    logic [31:0] drop_before;
`endif
    reset = 1'b1;
    bus.ImemReqReady = 1'b1; bus.InstReady = 1'b1;
    bus.BranchTaken = 1'b0;  bus.BranchTarget = '0;
    bus.ImemRspValid = 1'b0; bus.ImemRspData = '0;
    @(posedge clk); #1;
    tick();

    // Startup from RESET_PC, then a redirect to 0x203 coinciding with a response and a pop.
    vt[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   32'h0};
    vt[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,   32'h0};
    vt[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0,   32'h0};
    vt[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h203, 1'b0, 32'h0,   1'b1, 32'h104, f(32'h100)};
    vt[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h104, f(32'h100)};
    vt[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'h104, f(32'h100)};
    vt[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h204, f(32'h200)};
    vt[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h208, f(32'h204)};
    for (int i = 0; i < 8; i++) begin
      reset = vt[i].rst; bus.ImemReqReady = vt[i].rdy; bus.InstReady = vt[i].irdy;
      bus.BranchTaken = vt[i].br; bus.BranchTarget = vt[i].tgt;
      tick();
      check($sformatf("tbl%0d_rv", i), 32'(s_rv), 32'(vt[i].e_rv));
      if (vt[i].e_rv) check($sformatf("tbl%0d_addr", i), s_addr, vt[i].e_addr);
      check($sformatf("tbl%0d_iv", i), 32'(s_iv), 32'(vt[i].e_iv));
      check($sformatf("tbl%0d_p4", i), s_p4, vt[i].e_p4);
      check($sformatf("tbl%0d_inst", i), s_inst, vt[i].e_inst);
    end
    bus.BranchTaken = 1'b0;

    // Decode stall: head stable, credit fully used, nothing lost after release.
    for (int i = 0; i < 3; i++) tick();
    bus.InstReady = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k >= 1) check("stall_iv", 32'(s_iv), 32'd1);
      if (k == 1) begin hold_p4 = s_p4; hold_inst = s_inst; end
      if (k > 1) begin
        check("stall_p4_stable", s_p4, hold_p4);
        check("stall_inst_stable", s_inst, hold_inst);
      end
    end
    check("stall_no_req", 32'(s_rv), 32'd0);
    bus.InstReady = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    // Redirect with two requests in flight.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 30 && q.size() != 2; i++) tick();
    check("inflight_two", 32'(q.size()), 32'd2);
`ifdef IFETCH_STATS_EN
    drop_before = drop_count;
`endif
    issue_seen = 0;
    bus.BranchTaken = 1'b1; bus.BranchTarget = 32'h203;
    tick();
    bus.BranchTaken = 1'b0;
    wait_pop("redir_pop_timeout");
    check("redir_first_addr", first_issue, 32'h200);
    check("redir_first_p4", pop_p4, 32'h204);
    check("redir_first_inst", pop_inst, f(32'h200));
`ifdef IFETCH_STATS_EN
    check("redir_dropcount", drop_count - drop_before, 32'd2);
`endif

    // PC wrap from 0xFFFFFFFC to 0.
    lat_min = 1; lat_max = 1;
    bus.BranchTaken = 1'b1; bus.BranchTarget = 32'hFFFF_FFFE;
    tick();
    bus.BranchTaken = 1'b0;
    wait_pop("wrap_pop_timeout");
    check("wrap_p4", pop_p4, 32'h0);
    check("wrap_inst", pop_inst, f(32'hFFFF_FFFC));
    wait_pop("wrap_pop2_timeout");
    check("wrap_p4_next", pop_p4, 32'h4);

    // Spurious response with nothing outstanding must be ignored.
    reset = 1'b1; tick(); reset = 1'b0;
    bus.ImemReqReady = 1'b0; spurious = 1'b1; tick(); spurious = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("spurious_iv", 32'(s_iv), 32'd0);
    end
    bus.ImemReqReady = 1'b1;
    wait_pop("post_spurious_timeout");
    check("post_spurious_p4", pop_p4, RPC + 32'd4);

    // Random ready, decode stalls, redirects, latency 1-4, occasional reset.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 499) == 0);
      bus.ImemReqReady = $urandom_range(0, 1);
      bus.InstReady = ($urandom_range(0, 3) != 0);
      bus.BranchTaken = ($urandom_range(0, 39) == 0);
      bus.BranchTarget = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
      tick();
    end
    reset = 1'b0; bus.BranchTaken = 1'b0; bus.ImemReqReady = 1'b1; bus.InstReady = 1'b1;
    for (int i = 0; i < 10; i++) tick();
`ifdef IFETCH_STATS_EN
    check("stat_fetch", fetch_count, 32'(m_fetch));
    check("stat_drop", drop_count, 32'(m_drop));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Front end of the ARM pipeline. Holds the PC and issues word fetches to instruction memory over a valid/ready request port with an in-order response port.
- Buffers returned words in a small FIFO and presents Inst and PCPlus4 to the decode stage over a valid/ready handshake.
- Accepts branch redirects from execute. A redirect flushes buffered words and discards in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, FIFO entries; also the cap on outstanding requests plus buffered words. Minimum 2, power of two.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- ImemReqValid  output  1  fetch request valid
- ImemReqReady  input  1  memory accepts request
- ImemAddr  output  32  word-aligned fetch address
- ImemRspValid  input  1  response data valid; always accepted, never back-pressured
- ImemRspData  input  32  fetched instruction word
- InstValid  output  1  head entry valid toward decode
- InstReady  input  1  decode consumes head entry
- Inst  output  32  head instruction
- PCPlus4  output  32  head entry address + 4
- BranchTaken  input  1  redirect request
- BranchTarget  input  32  redirect address
- FetchCount  output  32  only with IFETCH_STATS_EN
- DropCount  output  32  only with IFETCH_STATS_EN

Behaviour:
- Reset values (all sampled at the clk edge):
  - PC = RESET_PC; FIFO empty; Outstanding = 0; Drop = 0.
  - ImemReqValid = 0 during the reset cycle.
  - InstValid = 0, Inst = 0, PCPlus4 = 0.
- Issue rule:
  - ImemReqValid = !reset && !BranchTaken && (Outstanding + FifoCount < DEPTH).
  - ImemAddr = PC.
  - On ImemReqValid && ImemReqReady: PC <= PC + 4 (32-bit wrap, 32'hFFFF_FFFC -> 0), and Outstanding increments.
  - The PC and the stored entry address are always word-aligned.
- Response rule:
  - Each ImemRspValid decrements Outstanding.
  - If Drop > 0, the word is discarded and Drop decrements.
  - Otherwise {ImemRspData, address} is pushed to the FIFO. Addresses are tracked in a shadow queue in issue order.
  - The credit rule guarantees the FIFO never overflows. An ImemRspValid with Outstanding == 0 is a protocol violation; ignore it and do not underflow.
- Latency:
  - A pushed word is visible at the FIFO head the cycle after the response; there is no combinational bypass.
  - Redirect in cycle C: first request in C+1; with a 1-cycle memory the response arrives in C+2 and InstValid rises in C+3.
- Output handshake:
  - InstValid = FIFO non-empty. Inst and PCPlus4 come from the head entry.
  - Pop when InstValid && InstReady.
  - When InstValid = 0, Inst and PCPlus4 hold their last values.
  - With InstReady = 0 the head is held stable.
  - Push and pop in the same cycle are both allowed: count unchanged, order preserved.
- Redirect (BranchTaken = 1):
  - PC <= {BranchTarget[31:2], 2'b00}; FIFO flushed; no request issued that cycle.
  - Drop <= Outstanding after this cycle's response decrement (all in-flight words).
  - Redirect takes priority over a simultaneous pop or push: the pushed word is discarded and InstValid is 0 next cycle.
  - Back-to-back redirects: the last one wins, and Drop is recomputed each time.
- Reset mid-operation clears all state. In-flight memory responses after reset are ignored by the Outstanding == 0 rule.
- The FIFO storage and shadow-address storage are not reset; only their pointers and counts are.

Optional Feature:
- Macro IFETCH_STATS_EN.
- When defined:
  - FetchCount counts words pushed into the FIFO.
  - DropCount counts words discarded by a flush or by Drop.
  - Both are 32-bit wrapping counters, cleared by reset.
- When undefined:
  - The ports and counters are absent.
  - All other behaviour is identical.

Test Plan:
- Reset with RESET_PC = 32'h100, ImemReqReady = 1, memory with 1-cycle latency, InstReady = 1 -> addresses 0x100, 0x104, 0x108… issued; InstValid stream shows PCPlus4 = 0x104, 0x108… with no gaps after fill.
- InstReady = 0 for 5 cycles -> at most DEPTH requests outstanding plus buffered; the head Inst/PCPlus4 stay stable; no lost or duplicated word after release.
- BranchTaken with BranchTarget = 32'h203 while 2 requests are in flight -> next ImemAddr = 0x200; both stale responses dropped (DropCount +2 with stats); first delivered PCPlus4 = 0x204.
- Redirect in the same cycle as an ImemRspValid and a pop -> response discarded, FIFO empty next cycle, no extra pop observed.
- PC at 32'hFFFF_FFFC -> next ImemAddr = 0; the entry for 0xFFFFFFFC shows PCPlus4 = 0.
- ImemReqReady toggling randomly plus variable response latency of 1–4 cycles, checked against a reference queue -> in-order delivery; Outstanding + FifoCount never exceeds DEPTH.
